// File: rtl/fetch_top.sv
// -----------------------------------------------------------------------------
// fetch_top -- instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Holds the fetch PC, a MEM_DEPTH x NB_DATA instruction memory (written via
// the debug loader port, read combinationally at the PC) and the IF/ID
// register consumed by decode. A LOAD/RUN/HALTED FSM sequences the stage.
//
// Build option:
//   FETCH_DELAY_SLOT_EN  defined   -> the instruction fetched alongside a
//                                     redirect is kept (MIPS delay slot).
//                        undefined -> that instruction is flushed to NOP_WORD.
//
// Ports:
//   clock_i, reset_i       clock and synchronous active-high reset
//   enable_i               debug step enable; 0 freezes RUN-state progress
//   start_i                LOAD -> RUN pulse
//   load_we_i/addr/data    instruction-memory loader (accepted in LOAD only)
//   stall_i                load-use stall from the hazard unit
//   pc_branch_or_jump_i    redirect request from decode
//   pc_src_i               redirect target select (00 br, 01 jmp, 10 reg, 11 br)
//   address_*_i            redirect targets
//   halt_i                 halt instruction sitting in decode
//   instruction_o          IF/ID instruction
//   pc_decode_o            IF/ID PC+1 of that instruction
//   pc_o                   current fetch PC
//   state_o                00 LOAD, 01 RUN, 10 HALTED
//   halted_o               high while HALTED
// -----------------------------------------------------------------------------
module fetch_top #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_PC     = 7,
  parameter int                 MEM_DEPTH = 128,
  parameter logic [NB_DATA-1:0] NOP_WORD  = 32'h00000000
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               start_i,
  input  logic               load_we_i,
  input  logic [NB_PC-1:0]   load_addr_i,
  input  logic [NB_DATA-1:0] load_data_i,
  input  logic               stall_i,
  input  logic               pc_branch_or_jump_i,
  input  logic [1:0]         pc_src_i,
  input  logic [NB_PC-1:0]   address_jump_i,
  input  logic [NB_PC-1:0]   address_branch_i,
  input  logic [NB_PC-1:0]   address_register_i,
  input  logic               halt_i,
  output logic [NB_DATA-1:0] instruction_o,
  output logic [NB_PC-1:0]   pc_decode_o,
  output logic [NB_PC-1:0]   pc_o,
  output logic [1:0]         state_o,
  output logic               halted_o
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'b00,
    ST_RUN     = 2'b01,
    ST_HALTED  = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q,  state_d;
  logic [NB_PC-1:0]   pc_q,     pc_d;
  logic [NB_DATA-1:0] instr_q,  instr_d;
  logic [NB_PC-1:0]   pc_dec_q, pc_dec_d;
  logic               halted_q, halted_d;

  // Instruction memory: combinational read at the PC, synchronous write.
  // Deliberately not reset so a program survives a reset.
  logic [NB_DATA-1:0] mem_q [MEM_DEPTH];
  logic               mem_we;

  logic [NB_DATA-1:0] fetch_word;
  logic [NB_PC-1:0]   pc_plus_one;
  logic [NB_PC-1:0]   redirect_target;

  assign fetch_word  = mem_q[pc_q];
  assign pc_plus_one = pc_q + NB_PC'(1);  // wraps modulo 2**NB_PC

  // Redirect target select; the reserved code 11 falls back to the branch target.
  always_comb begin
    redirect_target = address_branch_i;
    case (pc_src_i)
      2'b01:   redirect_target = address_jump_i;
      2'b10:   redirect_target = address_register_i;
      default: redirect_target = address_branch_i;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_dec_d = pc_dec_q;
    halted_d = halted_q;
    mem_we   = 1'b0;

    case (state_q)
      ST_LOAD: begin
        // Loader is live regardless of enable_i; a write coinciding with
        // start_i still lands before the FSM leaves LOAD.
        mem_we = load_we_i;
        if (start_i) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // A stall freezes the whole stage and masks halt/redirect that cycle.
        if (enable_i && !stall_i) begin
          if (halt_i) begin
            instr_d  = NOP_WORD;
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else if (pc_branch_or_jump_i) begin
            pc_d = redirect_target;
`ifdef FETCH_DELAY_SLOT_EN
            instr_d  = fetch_word;
            pc_dec_d = pc_plus_one;
`else
            instr_d  = NOP_WORD;
`endif
          end else begin
            instr_d  = fetch_word;
            pc_dec_d = pc_plus_one;
            pc_d     = pc_plus_one;
          end
        end
      end

      ST_HALTED: begin
        // Frozen until reset; start_i and the loader are ignored.
      end

      default: begin
        // Unused encoding: recover to a safe state.
        state_d = ST_LOAD;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_LOAD;
      pc_q     <= '0;
      instr_q  <= NOP_WORD;
      pc_dec_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_dec_q <= pc_dec_d;
      halted_q <= halted_d;
    end
  end

  // Loader writes are only produced in LOAD, and never during reset.
  always_ff @(posedge clock_i) begin
    if (mem_we && !reset_i) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  assign instruction_o = instr_q;
  assign pc_decode_o   = pc_dec_q;
  assign pc_o          = pc_q;
  assign state_o       = state_q;
  assign halted_o      = halted_q;

endmodule
